// File: rtl/ca_pkg.sv
// Shared types and default constants for the instruction-cache fill/clear controller.
package ca_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CLEAR = 2'd2
   } state_e;

   localparam int DEF_CACHE_ENTRIES   = 8;
   localparam int DEF_CNT_W           = 16;
   localparam int DEF_CLEAR_ON_RESET  = 1;
   localparam int DEF_FLUSH_ON_BRANCH = 1;

endpackage

// File: rtl/ca_wrap_cnt.sv
// Modulo-N up-counter with synchronous clear; serves as both the clear sweep
// index and the round-robin fill pointer.
module ca_wrap_cnt
   import ca_pkg::*;
#(
   parameter int N = DEF_CACHE_ENTRIES,
   parameter int W = $clog2(DEF_CACHE_ENTRIES)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] MAX = W'(N - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = (cnt_q == MAX) ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: serves hits, fills one entry per miss round-robin,
// and sweeps all valid bits clear after reset or on control-flow change.
//
// state | meaning
// IDLE  | lookups served from cache; a miss starts a fill, a branch starts a sweep
// FILL  | memory request outstanding; the ack cycle writes entry rr_ptr valid
// CLEAR | one entry invalidated per cycle, 0..CACHE_ENTRIES-1
module icache_ctrl
   import ca_pkg::*;
#(
   parameter int CACHE_ENTRIES   = DEF_CACHE_ENTRIES,
   parameter int CACHE_ADDR_LEFT = $clog2(CACHE_ENTRIES) - 1,
   parameter int CLEAR_ON_RESET  = DEF_CLEAR_ON_RESET,
   parameter int FLUSH_ON_BRANCH = DEF_FLUSH_ON_BRANCH,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_valid,
   input  logic                     cache_hit,
   input  logic                     branch_or_jump,
   input  logic                     mem_ack,
   output logic                     cache_read,
   output logic                     cache_write_,
   output logic [CACHE_ADDR_LEFT:0] cache_w_addr,
   output logic                     new_valid,
   output logic                     cache_stall,
   output logic                     mem_req,
   output logic [CNT_W-1:0]         hit_cnt,
   output logic [CNT_W-1:0]         miss_cnt
);

   localparam int                AW        = CACHE_ADDR_LEFT + 1;
   localparam logic [AW-1:0]     LAST      = AW'(CACHE_ENTRIES - 1);
   localparam logic              FOB       = (FLUSH_ON_BRANCH != 0);
   localparam state_e            RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

   state_e           state_q, state_d;
   logic             flush_pend_q, flush_pend_d;
   logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;
   logic [AW-1:0]    clr_cnt, rr_ptr;
   logic             clr_inc, clr_clr, rr_inc, rr_clr, hit_inc, miss_inc, flush;

   ca_wrap_cnt #(.N(CACHE_ENTRIES), .W(AW)) u_clr_cnt (
      .clk(clk), .rst(rst), .clr(clr_clr), .inc(clr_inc), .cnt_o(clr_cnt)
   );

   ca_wrap_cnt #(.N(CACHE_ENTRIES), .W(AW)) u_rr_ptr (
      .clk(clk), .rst(rst), .clr(rr_clr), .inc(rr_inc), .cnt_o(rr_ptr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RST_STATE;
         flush_pend_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         if (hit_inc && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
         if (miss_inc && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      cache_read   = 1'b0;
      cache_write_ = 1'b1;
      new_valid    = 1'b0;
      cache_w_addr = '0;
      cache_stall  = 1'b0;
      mem_req      = 1'b0;
      clr_inc      = 1'b0;
      rr_inc       = 1'b0;
      rr_clr       = 1'b0;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      flush        = branch_or_jump & FOB;
      clr_clr      = (state_q != CLEAR);

      unique case (state_q)
         IDLE: begin
            cache_read  = 1'b1;
            cache_stall = (fetch_valid & ~cache_hit) | flush;
            hit_inc     = fetch_valid & cache_hit;
            if (flush) begin
               state_d = CLEAR;
            end else if (fetch_valid && !cache_hit) begin
               state_d  = FILL;
               miss_inc = 1'b1;
            end
         end
         FILL: begin
            mem_req     = 1'b1;
            cache_stall = 1'b1;
            if (flush) flush_pend_d = 1'b1;
            if (mem_ack) begin
               cache_write_ = 1'b0;
               new_valid    = 1'b1;
               cache_w_addr = rr_ptr;
               rr_inc       = 1'b1;
               flush_pend_d = 1'b0;
               // A branch landing on the ack cycle itself still owes a sweep.
               state_d      = (flush_pend_q | flush) ? CLEAR : IDLE;
            end
         end
         CLEAR: begin
            cache_write_ = 1'b0;
            cache_w_addr = clr_cnt;
            cache_stall  = 1'b1;
            clr_inc      = 1'b1;
            rr_clr       = 1'b1;
            if (clr_cnt == LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         cache_read   = 1'b0;
         cache_write_ = 1'b1;
         new_valid    = 1'b0;
         cache_w_addr = '0;
         cache_stall  = 1'b1;
         mem_req      = 1'b0;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with 6 entries and 4-bit statistics counters.
module tb_icache_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fetch_valid = 1'b0;
   logic       cache_hit = 1'b0;
   logic       branch_or_jump = 1'b0;
   logic       mem_ack = 1'b0;
   logic       cache_read, cache_write_, new_valid, cache_stall, mem_req;
   logic [2:0] cache_w_addr;
   logic [3:0] hit_cnt, miss_cnt;

   int errors = 0;
   int checks = 0;

   icache_ctrl #(
      .CACHE_ENTRIES(6), .CLEAR_ON_RESET(1), .FLUSH_ON_BRANCH(1), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .cache_hit(cache_hit),
      .branch_or_jump(branch_or_jump), .mem_ack(mem_ack),
      .cache_read(cache_read), .cache_write_(cache_write_), .cache_w_addr(cache_w_addr),
      .new_valid(new_valid), .cache_stall(cache_stall), .mem_req(mem_req),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic miss_fill(input int lat, output logic [2:0] a, output logic nv,
                            output logic wn, output int nreq);
      nreq = 0;
      @(negedge clk); fetch_valid = 1'b1; cache_hit = 1'b0;
      @(negedge clk); fetch_valid = 1'b0;
      for (int j = 0; j < lat; j++) begin
         #1; if (mem_req) nreq++;
         @(negedge clk);
      end
      mem_ack = 1'b1;
      #1; if (mem_req) nreq++;
      a = cache_w_addr; nv = new_valid; wn = cache_write_;
      @(negedge clk); mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      checks++;
      if ({cache_write_, new_valid, mem_req, cache_read, cache_stall, cache_w_addr} !== {5'b10001, 3'd0}) begin
         errors++;
         $display("FAIL reset_outputs: got we_n=%b nv=%b req=%b rd=%b st=%b addr=%0d, expected 1 0 0 0 1 0",
                  cache_write_, new_valid, mem_req, cache_read, cache_stall, cache_w_addr);
      end
      checks++;
      if ({hit_cnt, miss_cnt} !== 8'h00) begin
         errors++;
         $display("FAIL reset_counters: got hit=%0d miss=%0d expected 0 0", hit_cnt, miss_cnt);
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (cache_write_ !== 1'b0 || new_valid !== 1'b0 || cache_w_addr !== 3'(i) ||
             cache_stall !== 1'b1 || cache_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_sweep[%0d]: got we_n=%b nv=%b addr=%0d st=%b rd=%b expected 0 0 %0d 1 0",
                     i, cache_write_, new_valid, cache_w_addr, cache_stall, cache_read, i);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (cache_read !== 1'b1 || cache_write_ !== 1'b1 || cache_stall !== 1'b0) begin
         errors++;
         $display("FAIL sweep_to_idle: got rd=%b we_n=%b st=%b expected 1 1 0",
                  cache_read, cache_write_, cache_stall);
      end
   endtask

   task automatic test_miss();
      logic [2:0] a; logic nv, wn; int nreq;
      miss_fill(3, a, nv, wn, nreq);
      checks++;
      if (nreq !== 4) begin
         errors++; $display("FAIL miss_req_cycles: got %0d expected 4", nreq);
      end
      checks++;
      if (a !== 3'd0 || nv !== 1'b1 || wn !== 1'b0) begin
         errors++; $display("FAIL miss_write: got addr=%0d nv=%b we_n=%b expected 0 1 0", a, nv, wn);
      end
      #1;
      checks++;
      if (mem_req !== 1'b0 || cache_read !== 1'b1 || miss_cnt !== 4'd1) begin
         errors++;
         $display("FAIL miss_done: got req=%b rd=%b miss_cnt=%0d expected 0 1 1", mem_req, cache_read, miss_cnt);
      end
      miss_fill(0, a, nv, wn, nreq);
      checks++;
      if (a !== 3'd1 || nreq !== 1) begin
         errors++; $display("FAIL rr_advance: got addr=%0d req_cycles=%0d expected 1 1", a, nreq);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fetch_valid = 1'b1; cache_hit = 1'b0;
      for (int k = 0; k < 7; k++) begin
         #1;
         checks++;
         if (mem_req !== 1'b0 || cache_stall !== 1'b1) begin
            errors++; $display("FAIL b2b_idle[%0d]: got req=%b st=%b expected 0 1", k, mem_req, cache_stall);
         end
         @(negedge clk); mem_ack = 1'b1;
         #1;
         checks++;
         if (cache_w_addr !== 3'(k % 6) || cache_write_ !== 1'b0 || new_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fill[%0d]: got addr=%0d we_n=%b nv=%b expected %0d 0 1",
                     k, cache_w_addr, cache_write_, new_valid, k % 6);
         end
         @(negedge clk); mem_ack = 1'b0;
      end
      fetch_valid = 1'b0;
      #1;
      checks++;
      if (miss_cnt !== 4'd7) begin
         errors++; $display("FAIL b2b_miss_cnt: got %0d expected 7", miss_cnt);
      end
   endtask

   task automatic test_branch_in_fill();
      logic [2:0] a; logic nv, wn; int nreq;
      @(negedge clk); fetch_valid = 1'b1;
      @(negedge clk); fetch_valid = 1'b0;
      @(negedge clk); branch_or_jump = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b1 || cache_stall !== 1'b1 || cache_write_ !== 1'b1) begin
         errors++;
         $display("FAIL bif_no_abort: got req=%b st=%b we_n=%b expected 1 1 1", mem_req, cache_stall, cache_write_);
      end
      @(negedge clk); branch_or_jump = 1'b0;
      @(negedge clk); mem_ack = 1'b1;
      #1;
      checks++;
      if (cache_write_ !== 1'b0 || new_valid !== 1'b1 || cache_w_addr !== 3'd1) begin
         errors++;
         $display("FAIL bif_fill: got we_n=%b nv=%b addr=%0d expected 0 1 1", cache_write_, new_valid, cache_w_addr);
      end
      @(negedge clk); mem_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         branch_or_jump = (i == 2);
         #1;
         checks++;
         if (cache_write_ !== 1'b0 || new_valid !== 1'b0 || cache_w_addr !== 3'(i) || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL bif_sweep[%0d]: got we_n=%b nv=%b addr=%0d req=%b expected 0 0 %0d 0",
                     i, cache_write_, new_valid, cache_w_addr, mem_req, i);
         end
         @(negedge clk);
      end
      branch_or_jump = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (cache_read !== 1'b1 || cache_write_ !== 1'b1 || cache_stall !== 1'b0) begin
            errors++;
            $display("FAIL bif_single_sweep[%0d]: got rd=%b we_n=%b st=%b expected 1 1 0",
                     i, cache_read, cache_write_, cache_stall);
         end
         @(negedge clk);
      end
      miss_fill(0, a, nv, wn, nreq);
      checks++;
      if (a !== 3'd0) begin
         errors++; $display("FAIL rr_after_clear: got addr=%0d expected 0", a);
      end
   endtask

   task automatic test_branch_idle();
      logic [3:0] m0;
      @(negedge clk); m0 = miss_cnt;
      fetch_valid = 1'b1; cache_hit = 1'b0; branch_or_jump = 1'b1;
      #1;
      checks++;
      if (cache_stall !== 1'b1) begin
         errors++; $display("FAIL branch_idle_stall: got %b expected 1", cache_stall);
      end
      @(negedge clk); fetch_valid = 1'b0; branch_or_jump = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || cache_write_ !== 1'b0 || cache_w_addr !== 3'd0 || miss_cnt !== m0) begin
         errors++;
         $display("FAIL branch_priority: got req=%b we_n=%b addr=%0d miss=%0d expected 0 0 0 %0d",
                  mem_req, cache_write_, cache_w_addr, miss_cnt, m0);
      end
      repeat (6) @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || cache_write_ !== 1'b1 || cache_read !== 1'b1) begin
         errors++;
         $display("FAIL stray_ack: got req=%b we_n=%b rd=%b expected 0 1 1", mem_req, cache_write_, cache_read);
      end
   endtask

   task automatic test_hit_sat();
      @(negedge clk); fetch_valid = 1'b1; cache_hit = 1'b1;
      #1;
      checks++;
      if (cache_stall !== 1'b0 || cache_read !== 1'b1) begin
         errors++; $display("FAIL hit_no_stall: got st=%b rd=%b expected 0 1", cache_stall, cache_read);
      end
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (hit_cnt !== 4'd5) begin
         errors++; $display("FAIL hit_cnt_5: got %0d expected 5", hit_cnt);
      end
      repeat (15) @(negedge clk);
      fetch_valid = 1'b0; cache_hit = 1'b0;
      #1;
      checks++;
      if (hit_cnt !== 4'd15) begin
         errors++; $display("FAIL hit_cnt_sat: got %0d expected 15", hit_cnt);
      end
   endtask

   task automatic test_reset_mid_clear();
      @(negedge clk); branch_or_jump = 1'b1;
      @(negedge clk); branch_or_jump = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (cache_w_addr !== 3'd3 || cache_write_ !== 1'b0) begin
         errors++; $display("FAIL mid_clear_addr: got addr=%0d we_n=%b expected 3 0", cache_w_addr, cache_write_);
      end
      rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({cache_write_, new_valid, mem_req, cache_read, cache_stall, cache_w_addr} !== {5'b10001, 3'd0} ||
          hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
         errors++;
         $display("FAIL mid_clear_reset: got we_n=%b nv=%b req=%b rd=%b st=%b addr=%0d hit=%0d miss=%0d expected 1 0 0 0 1 0 0 0",
                  cache_write_, new_valid, mem_req, cache_read, cache_stall, cache_w_addr, hit_cnt, miss_cnt);
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (cache_w_addr !== 3'(i) || cache_write_ !== 1'b0) begin
            errors++;
            $display("FAIL restart_sweep[%0d]: got addr=%0d we_n=%b expected %0d 0", i, cache_w_addr, cache_write_, i);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (cache_read !== 1'b1 || cache_stall !== 1'b0) begin
         errors++; $display("FAIL restart_idle: got rd=%b st=%b expected 1 0", cache_read, cache_stall);
      end
   endtask

   initial begin
      test_reset();
      test_miss();
      test_back_to_back();
      test_branch_in_fill();
      test_branch_idle();
      test_hit_sat();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
